// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM encoding,
// and the access-size decoder used at request accept.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_RMW_RD = 3'd2,
    ST_WRITE  = 3'd3,
    ST_RESP   = 3'd4
  } lsu_state_t;

  typedef enum logic [1:0] {
    SZ_BYTE    = 2'd0,
    SZ_HALF    = 2'd1,
    SZ_WORD    = 2'd2,
    SZ_ILLEGAL = 2'd3
  } lsu_size_t;

  // Stores only know B/H/W; the unsigned variants are load-only.
  function automatic lsu_size_t decode_size(input logic we, input logic [2:0] funct3);
    lsu_size_t size;
    size = SZ_ILLEGAL;
    case (funct3)
      F3_B:  size = SZ_BYTE;
      F3_H:  size = SZ_HALF;
      F3_W:  size = SZ_WORD;
      F3_BU: size = we ? SZ_ILLEGAL : SZ_BYTE;
      F3_HU: size = we ? SZ_ILLEGAL : SZ_HALF;
      default: size = SZ_ILLEGAL;
    endcase
    return size;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane steering: load extraction with sign/zero extension and
// sub-word store merging into an existing memory word.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] load_value,
  output logic [31:0] merged_word
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Pick the addressed lane and extend it to 32 bits for loads.
  always_comb begin
    byte_sel = word[7:0];
    case (addr_lo)
      2'd0: byte_sel = word[7:0];
      2'd1: byte_sel = word[15:8];
      2'd2: byte_sel = word[23:16];
      2'd3: byte_sel = word[31:24];
      default: byte_sel = word[7:0];
    endcase
    half_sel = addr_lo[1] ? word[31:16] : word[15:0];
    case (funct3)
      F3_B:    load_value = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   load_value = {24'h0, byte_sel};
      F3_H:    load_value = {{16{half_sel[15]}}, half_sel};
      F3_HU:   load_value = {16'h0, half_sel};
      default: load_value = word;
    endcase
  end

  // Overlay the store byte/half onto the word just read from memory.
  always_comb begin
    merged_word = word;
    case (funct3)
      F3_B: begin
        case (addr_lo)
          2'd0: merged_word[7:0]   = wdata[7:0];
          2'd1: merged_word[15:8]  = wdata[7:0];
          2'd2: merged_word[23:16] = wdata[7:0];
          2'd3: merged_word[31:24] = wdata[7:0];
          default: merged_word = word;
        endcase
      end
      F3_H: begin
        if (addr_lo[1]) merged_word[31:16] = wdata[15:0];
        else            merged_word[15:0]  = wdata[15:0];
      end
      default: merged_word = wdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: single-outstanding memory master with fault detection,
// load lane extraction and read-modify-write for byte/half stores.
// Handshake: a request transfers on the rising edge where req_valid && req_ready;
// req_ready is high only in IDLE, and resp_valid is a one-cycle pulse that
// needs no acknowledge.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_WORDS = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_fault,
  output logic        MemRead,
  output logic        MemWrite,
  output logic [31:0] Mem_Addr,
  output logic [31:0] wr_data,
  input  logic [31:0] rd_data
);

  localparam logic [29:0] WORD_LIMIT = 30'(MEM_WORDS);

  lsu_state_t  state, state_next;
  lsu_size_t   req_size;
  logic        accept;
  logic        req_fault;
  logic [31:0] addr_q;
  logic [2:0]  funct3_q;
  logic [31:0] wdata_q;
  logic [31:0] merged_q;
  logic [31:0] resp_rdata_q;
  logic        resp_fault_q;
  logic [31:0] load_value;
  logic [31:0] merged_word;

  assign req_ready = (state == ST_IDLE) && !reset;
  assign accept    = req_valid && req_ready;

  // Classify the incoming request; faulting requests never reach memory.
  always_comb begin
    req_size  = decode_size(req_we, req_funct3);
    req_fault = (req_size == SZ_ILLEGAL)
             || ((req_size == SZ_HALF) && req_addr[0])
             || ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00))
             || (req_addr[31:2] >= WORD_LIMIT);
  end

  lsu_lane_align u_align (
    .word        (rd_data),
    .wdata       (wdata_q),
    .addr_lo     (addr_q[1:0]),
    .funct3      (funct3_q),
    .load_value  (load_value),
    .merged_word (merged_word)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Next-state: route by fault, direction and store width at accept.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (req_fault)                 state_next = ST_RESP;
          else if (!req_we)              state_next = ST_LOAD;
          else if (req_size == SZ_WORD)  state_next = ST_WRITE;
          else                           state_next = ST_RMW_RD;
        end
      end
      ST_LOAD:   state_next = ST_RESP;
      ST_RMW_RD: state_next = ST_WRITE;
      ST_WRITE:  state_next = ST_RESP;
      ST_RESP:   state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // Memory strobes and response pulse; address/data are zero when no access runs.
  always_comb begin
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    Mem_Addr   = 32'h0;
    wr_data    = 32'h0;
    resp_valid = 1'b0;
    if (!reset) begin
      case (state)
        ST_LOAD, ST_RMW_RD: begin
          MemRead  = 1'b1;
          Mem_Addr = {2'b00, addr_q[31:2]};
        end
        ST_WRITE: begin
          MemWrite = 1'b1;
          Mem_Addr = {2'b00, addr_q[31:2]};
          wr_data  = merged_q;
        end
        ST_RESP:  resp_valid = 1'b1;
        default: ;
      endcase
    end
  end

  // Request capture, RMW merge and response registers (held until the next RESP).
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q       <= 32'h0;
      funct3_q     <= 3'h0;
      wdata_q      <= 32'h0;
      merged_q     <= 32'h0;
      resp_rdata_q <= 32'h0;
      resp_fault_q <= 1'b0;
    end else begin
      if (accept) begin
        addr_q   <= req_addr;
        funct3_q <= req_funct3;
        wdata_q  <= req_wdata;
        merged_q <= req_wdata;  // a full-word store writes this unchanged
        if (req_fault) begin
          resp_rdata_q <= 32'h0;
          resp_fault_q <= 1'b1;
        end
      end
      if (state == ST_LOAD) begin
        resp_rdata_q <= load_value;
        resp_fault_q <= 1'b0;
      end
      if (state == ST_RMW_RD) merged_q <= merged_word;
      if (state == ST_WRITE) begin
        resp_rdata_q <= 32'h0;
        resp_fault_q <= 1'b0;
      end
    end
  end

  assign resp_rdata = resp_rdata_q;
  assign resp_fault = resp_fault_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: attached 64-word memory, a transaction-level
// reference model with expected queues, a per-cycle compare process and
// hand-computed literal checks.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_fault;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] Mem_Addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;

  logic [31:0] mem     [0:63];
  logic [31:0] ref_mem [0:63];
  logic [32:0] exp_q[$];   // {fault, rdata}
  logic [63:0] wr_q[$];    // {word index, data}

  int n_checks = 0;
  int n_fail   = 0;

  load_store_unit #(.MEM_WORDS(64)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_fault (resp_fault),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .Mem_Addr   (Mem_Addr),
    .wr_data    (wr_data),
    .rd_data    (rd_data)
  );

  // Clock
  always #5 clk = ~clk;

  // Attached memory: combinational read, write on the clock edge
  assign rd_data = (MemRead && Mem_Addr < 32'd64) ? mem[Mem_Addr[5:0]] : 32'h0;
  always @(posedge clk) begin
    if (MemWrite && Mem_Addr < 32'd64) mem[Mem_Addr[5:0]] <= wr_data;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: event with no expectation queued", name);
  endtask

  // Reference model: expected result of one access from the access rules alone.
  task automatic model_access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wdata, output int lat, output int reads,
                              output int writes);
    int nbytes;
    bit legal;
    bit fault;
    logic [31:0] word, lane, sh, mask, rdata;
    int idx;
    legal  = we ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    nbytes = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    fault  = !legal || (addr % nbytes != 0) || ((addr >> 2) >= 64);
    rdata  = 32'h0;
    reads = 0; writes = 0;
    if (fault) begin
      lat = 1;
    end else begin
      idx  = int'(addr >> 2);
      word = ref_mem[idx];
      sh   = 8 * (addr % 4);
      mask = (nbytes == 1) ? 32'hFF : (nbytes == 2) ? 32'hFFFF : 32'hFFFF_FFFF;
      if (!we) begin
        lat = 2; reads = 1;
        lane = (word >> sh) & mask;
        if (f3 == 3'd0)      rdata = lane - ((lane & 32'h80) << 1);
        else if (f3 == 3'd1) rdata = lane - ((lane & 32'h8000) << 1);
        else                 rdata = lane;
      end else begin
        writes = 1;
        if (nbytes == 4) begin
          lat = 2;
          word = wdata;
        end else begin
          lat = 3; reads = 1;
          word = (word & ~(mask << sh)) | ((wdata & mask) << sh);
        end
        ref_mem[idx] = word;
        wr_q.push_back({32'(idx), word});
      end
    end
    exp_q.push_back({fault, rdata});
  endtask

  // Drive one request and measure latency and strobe counts up to the response.
  task automatic run_req(input string name, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata);
    int exp_lat, exp_reads, exp_writes;
    int lat, reads, writes;
    bit got;
    model_access(we, f3, addr, wdata, exp_lat, exp_reads, exp_writes);
    @(negedge clk);
    chk({name, "_ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0; reads = 0; writes = 0; got = 0;
    for (int c = 1; c <= 6 && !got; c++) begin
      @(negedge clk);
      if (MemRead)  reads++;
      if (MemWrite) writes++;
      if (resp_valid) begin
        got = 1;
        lat = c;
      end
    end
    chk({name, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({name, "_reads"}, 32'(reads), 32'(exp_reads));
    chk({name, "_writes"}, 32'(writes), 32'(exp_writes));
  endtask

  // Per-cycle compare against the model's queues and the interface invariants.
  always @(negedge clk) begin
    logic [32:0] e;
    logic [63:0] w;
    if (!reset) begin
      chk("rw_exclusive", 32'(MemRead & MemWrite), 32'd0);
      if (!MemRead && !MemWrite) begin
        chk("idle_addr", Mem_Addr, 32'h0);
        chk("idle_wdata", wr_data, 32'h0);
      end
      if (MemWrite) begin
        if (wr_q.size() == 0) fail_now("unexpected_write");
        else begin
          w = wr_q.pop_front();
          chk("write_addr", Mem_Addr, w[63:32]);
          chk("write_data", wr_data, w[31:0]);
        end
      end
      if (resp_valid) begin
        if (exp_q.size() == 0) fail_now("unexpected_resp");
        else begin
          e = exp_q.pop_front();
          chk("resp_fault", 32'(resp_fault), 32'(e[32]));
          chk("resp_rdata", resp_rdata, e[31:0]);
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 64; i++) begin
      mem[i]     = 32'h0101_0101 * i;
      ref_mem[i] = 32'h0101_0101 * i;
    end
    mem[5] = 32'h8899AABB; ref_mem[5] = 32'h8899AABB;
    mem[3] = 32'h11223344; ref_mem[3] = 32'h11223344;
    mem[8] = 32'h55667788; ref_mem[8] = 32'h55667788;
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'h0; req_wdata = 32'h0;

    // Reset behaviour
    @(negedge clk);
    chk("rst_memread", 32'(MemRead), 32'd0);
    chk("rst_memwrite", 32'(MemWrite), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 32'(req_ready), 32'd1);
    chk("post_rst_rdata", resp_rdata, 32'h0);
    chk("post_rst_fault", 32'(resp_fault), 32'd0);

    // Loads from word 5 = 0x8899AABB
    run_req("lb_17", 1'b0, 3'b000, 32'h17, 32'h0);
    chk("lb_17_lit", resp_rdata, 32'hFFFFFF88);
    run_req("lhu_14", 1'b0, 3'b101, 32'h14, 32'h0);
    chk("lhu_14_lit", resp_rdata, 32'h0000AABB);
    run_req("lh_16", 1'b0, 3'b001, 32'h16, 32'h0);
    chk("lh_16_lit", resp_rdata, 32'hFFFF8899);
    run_req("lbu_15", 1'b0, 3'b100, 32'h15, 32'h0);
    chk("lbu_15_lit", resp_rdata, 32'h000000AA);
    run_req("lw_14", 1'b0, 3'b010, 32'h14, 32'h0);

    // Byte store via read-modify-write, then read back
    run_req("sb_0d", 1'b1, 3'b000, 32'h0D, 32'h0000_00AA);
    chk("sb_0d_mem", mem[3], 32'h1122AA44);
    run_req("lw_0c", 1'b0, 3'b010, 32'h0C, 32'h0);
    chk("lw_0c_lit", resp_rdata, 32'h1122AA44);

    // Word store and half store
    run_req("sw_08", 1'b1, 3'b010, 32'h08, 32'hDEADBEEF);
    chk("sw_08_rdata_lit", resp_rdata, 32'h0);
    run_req("lw_08", 1'b0, 3'b010, 32'h08, 32'h0);
    chk("lw_08_lit", resp_rdata, 32'hDEADBEEF);
    run_req("sh_12", 1'b1, 3'b001, 32'h12, 32'h1234CAFE);
    run_req("lw_10", 1'b0, 3'b010, 32'h10, 32'h0);
    chk("lw_10_lit", resp_rdata, 32'hCAFE0404);
    run_req("sb_fc", 1'b1, 3'b000, 32'hFC, 32'h0000_0077);
    run_req("lb_fc", 1'b0, 3'b000, 32'hFC, 32'h0);
    chk("lb_fc_lit", resp_rdata, 32'h00000077);

    // Faults
    run_req("flt_lw_06", 1'b0, 3'b010, 32'h06, 32'h0);
    chk("flt_lw_06_lit", 32'(resp_fault), 32'd1);
    run_req("flt_sh_03", 1'b1, 3'b001, 32'h03, 32'h1234);
    chk("flt_sh_03_lit", 32'(resp_fault), 32'd1);
    run_req("flt_lw_100", 1'b0, 3'b010, 32'h100, 32'h0);
    chk("flt_lw_100_lit", 32'(resp_fault), 32'd1);
    run_req("flt_f3_011", 1'b0, 3'b011, 32'h10, 32'h0);
    chk("flt_f3_011_rdata", resp_rdata, 32'h0);
    run_req("flt_sbu", 1'b1, 3'b100, 32'h10, 32'h0);
    run_req("lw_00", 1'b0, 3'b010, 32'h00, 32'h0);
    chk("lw_00_fault_lit", 32'(resp_fault), 32'd0);

    // Reset during the WRITE cycle of a byte store aborts it
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000; req_addr = 32'h21; req_wdata = 32'h11;
    @(posedge clk);                   // accept
    #1 req_valid = 1'b0;
    @(posedge clk);                   // RMW_RD -> WRITE
    #1 reset = 1'b1;
    @(negedge clk);
    chk("abort_memwrite", 32'(MemWrite), 32'd0);
    chk("abort_resp_valid", 32'(resp_valid), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("abort_ready", 32'(req_ready), 32'd1);
    chk("abort_no_resp", 32'(resp_valid), 32'd0);
    chk("abort_mem", mem[8], 32'h55667788);
    repeat (2) @(negedge clk);

    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
    chk("wr_q_drained", 32'(wr_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Initiator side of the word-wide data memory interface: the master that drives MemRead/MemWrite/Mem_Addr/wr_data and consumes rd_data.
- Accepts byte, halfword and word load/store requests from the core using a valid/ready handshake.
- Performs lane extraction and sign/zero extension for loads.
- Performs read-modify-write for sub-word stores, because the memory has no byte enables.
- Flags misaligned, out-of-range and illegal-funct3 accesses without touching memory.

Parameters:
- MEM_WORDS, 64: number of 32-bit words in the attached memory; word index >= MEM_WORDS faults.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  core request valid
- req_ready  out  1  LSU can accept a request
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I load/store funct3
- req_addr  in  32  byte address
- req_wdata  in  32  store data; low byte/half used for SB/SH
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  extended load data; 0 for stores and faults
- resp_fault  out  1  access faulted (valid only with resp_valid)
- MemRead  out  1  memory read enable
- MemWrite  out  1  memory write enable
- Mem_Addr  out  32  word index = {2'b00, addr[31:2]}
- wr_data  out  32  memory write data
- rd_data  in  32  combinational memory read data, valid in the same cycle as MemRead

Behaviour:
- States: IDLE, LOAD, RMW_RD, WRITE, RESP.
- Reset: state=IDLE; all registered fields cleared. MemRead, MemWrite and resp_valid are 0 during the reset cycle. resp_rdata=0, resp_fault=0. req_ready=1 from the first cycle after reset deasserts.
- req_ready = (state==IDLE) && !reset. Handshake completes on req_valid && req_ready. The request is captured (addr, funct3, we, wdata) on that edge. There is no request pipelining: exactly one access is outstanding at a time.
- Decode at accept:
  - Loads: funct3 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Any other funct3 is illegal.
- A fault is raised if any of these hold; a faulting request goes IDLE->RESP with resp_fault=1, resp_rdata=0, and no MemRead/MemWrite ever asserted:
  - illegal funct3;
  - halfword access with addr[0]=1;
  - word access with addr[1:0]!=0;
  - addr[31:2] >= MEM_WORDS.
- Load: IDLE->LOAD->RESP.
  - In LOAD, MemRead=1 and Mem_Addr is driven.
  - The selected lane is taken from rd_data (byte lane addr[1:0], half lane addr[1]), sign- or zero-extended, and registered into resp_rdata.
- SW: IDLE->WRITE->RESP. In WRITE, MemWrite=1 and wr_data=req_wdata.
- SB/SH: IDLE->RMW_RD->WRITE->RESP.
  - In RMW_RD, MemRead=1. rd_data is merged with the store byte/half in the addressed lane, and the merged word is registered.
  - In WRITE, MemWrite=1 with the merged word.
- RESP: resp_valid=1 for exactly one cycle, then IDLE. resp_rdata and resp_fault hold their value until the next RESP.
- Latency, counted from the accept edge at cycle T:
  - fault: resp_valid at T+1;
  - load and SW: resp_valid at T+2;
  - SB/SH: resp_valid at T+3.
- MemRead and MemWrite are never both 1. Outside LOAD, RMW_RD and WRITE, both are 0, and Mem_Addr and wr_data are 0.
- MemWrite = (state==WRITE) && !reset, so asserting reset in the WRITE cycle suppresses the write. Reset in any state aborts the access and emits no response.
- A back-to-back request may be accepted in the cycle after RESP (IDLE); holding req_valid high is legal.

Decomposition:
- Package lsu_pkg holds:
  - funct3 localparams F3_B, F3_H, F3_W, F3_BU, F3_HU;
  - the state encoding (IDLE..RESP);
  - a function that decodes the access size.
- One sub-module, lsu_lane_align, is purely combinational:
  - load_extract(word, addr[1:0], funct3) -> 32-bit extended value;
  - store_merge(old_word, wdata, addr[1:0], funct3) -> 32-bit merged word.

Test Plan:
- Memory word 5 = 0x8899AABB; LB at addr 0x17 -> resp_rdata=0xFFFFFF88, resp_valid at T+2, MemRead high for exactly one cycle.
- Same word; LHU at addr 0x14 -> 0x0000AABB; LH at addr 0x16 -> 0xFFFF8899.
- Word 3 = 0x11223344; SB addr 0x0D, wdata=0xAA -> RMW read then write of 0x1122AA44 to Mem_Addr 3; resp at T+3; subsequent LW at 0x0C returns 0x1122AA44.
- SW addr 0x08, wdata=0xDEADBEEF -> MemWrite exactly one cycle at Mem_Addr 2, no MemRead, resp at T+2.
- Faults, each -> resp_fault=1 at T+1, MemRead and MemWrite never asserted:
  - LW addr 0x06;
  - SH addr 0x03;
  - LW addr 0x100 (word index 64);
  - funct3=011.
- SB issued, reset asserted in the WRITE cycle -> MemWrite stays 0, memory unchanged, no resp_valid, req_ready=1 in the cycle after reset deasserts.
